mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Parametrised memory-access controller holding the MAR, MDR and IR of the datapath and running a handshaked read/write to external memory with a bounded wait. It sits between the register bank / ALU buses (busC, bus_alu) and the memory port. It generalises the fixed 8-bit, single-cycle memory path to configurable widths, variable memory latency (ack-based), and timeout error reporting.

## Interface
- DATA_WIDTH, 8, width of buses, MDR, memory data
- ADDR_WIDTH, 8, width of MAR / memory address (≤ DATA_WIDTH)
- INSTR_WIDTH, 5, width of IR (≤ DATA_WIDTH)
- TIMEOUT, 15, max access cycles without ack before abort (≥ 1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- busC  in  DATA_WIDTH  MAR load source (low ADDR_WIDTH bits); alternate MDR source
- bus_alu  in  DATA_WIDTH  MDR load source
- mar_en / mar_sclr  in  1  MAR load / synchronous clear
- mdr_en  in  1  MDR load from bus
- mdr_alu_n  in  1  MDR source: 0 = bus_alu, 1 = busC
- ir_en / ir_sclr  in  1  IR load from MDR / synchronous clear
- mem_req  in  1  start access (sampled in IDLE only)
- wr_rdn  in  1  access direction at mem_req: 1 = write, 0 = read
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes current access
- mem_addr  out  ADDR_WIDTH  = MAR
- mem_wdata  out  DATA_WIDTH  = MDR
- mem_cs  out  1  high in READ and WRITE
- mem_we  out  1  high in WRITE only
- mdr_q  out  DATA_WIDTH  MDR contents
- instruction  out  INSTR_WIDTH  IR contents
- busy  out  1  high in READ and WRITE
- done  out  1  one-cycle pulse, access completed
- err  out  1  one-cycle pulse, access timed out

## Operation
- FSM states: IDLE, READ, WRITE. IDLE + mem_req → READ (wr_rdn=0) or WRITE (wr_rdn=1); direction latched at entry.
- READ/WRITE: cycle counter cnt (width clog2(TIMEOUT+1)) starts at 0 on entry, +1 per edge without ack.
- mem_ack sampled in READ: MDR ← mem_rdata, state → IDLE, done=1 next cycle. In WRITE: state → IDLE, done=1 next cycle, MDR unchanged.
- No ack at an edge where cnt == TIMEOUT−1: state → IDLE, err=1 next cycle, MDR unchanged. Ack on that same edge wins (done, no err).
- mem_ack in IDLE ignored; mem_req while busy ignored.
- While busy: mar_en, mar_sclr, mdr_en ignored (MAR/MDR frozen so mem_addr/mem_wdata stable). ir_en/ir_sclr honoured at all times.
- Priority: mar_sclr > mar_en; ir_sclr > ir_en; read-ack MDR load > mdr_en (mdr_en only acts in IDLE anyway).
- MAR ← busC[ADDR_WIDTH−1:0]. IR ← MDR[DATA_WIDTH−1 -: INSTR_WIDTH] (old MDR value when ir_en coincides with a read-ack edge).
- Reset: state IDLE, cnt 0, MAR/MDR/IR 0, mem_cs/mem_we/busy/done/err 0; reset mid-access aborts with no done/err.

## Timing
- mem_req sampled at edge k → mem_cs (and mem_we for write), busy high from k+1.
- Ack sampled at edge m (m ≥ k+1) → mdr_q updated after m; busy, mem_cs low and done high for cycle after m; minimum request-to-done latency 2 edges.
- No ack → mem_cs high exactly TIMEOUT cycles, err high the cycle after the last one.
- New mem_req accepted in the cycle done/err is high (state already IDLE).
- done, err, mem_cs, mem_we, busy are registered outputs; mem_addr, mem_wdata, mdr_q, instruction are register outputs, no combinational paths from inputs.

## Test plan
- Reset: hold rst 2 cycles with mar_en, mdr_en, mem_req all 1 → all outputs 0, state IDLE after release.
- Write: busC=0x3C, mar_en; bus_alu=0xA5, mdr_en, mdr_alu_n=0; mem_req, wr_rdn=1; ack after 3 cycles → mem_we high 3 cycles with mem_addr=0x3C, mem_wdata=0xA5, done one pulse, MDR stays 0xA5.
- Read + IR: MAR=0x10, read, mem_rdata=0xB7 with ack on first cycle → mdr_q=0xB7, done after 2 edges; ir_en next cycle → instruction=5'b10110.
- Timeout (TIMEOUT=4): read, never ack → mem_cs high 4 cycles, err one pulse, done 0, MDR unchanged; ack on 4th cycle instead → done, no err.
- Frozen while busy: during READ pulse mar_en with busC=0xFF and mdr_en → mem_addr and mdr_q unchanged; mem_req mid-access ignored; ir_sclr+ir_en same cycle → instruction=0.
- Reset mid-access: rst during WRITE cycle 2 → mem_cs/mem_we/busy drop after that edge, no done/err, MAR/MDR = 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Holds the MAR, MDR and IR of the datapath. Runs one handshaked read or
// write to external memory at a time, and aborts the access if no ack
// arrives within TIMEOUT cycles.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   busC                  MAR load source (low ADDR_WIDTH bits), alternate MDR source
//   bus_alu               MDR load source
//   mar_en, mar_sclr      MAR load / clear (ignored while busy)
//   mdr_en, mdr_alu_n     MDR load from bus, source select (0 = bus_alu, 1 = busC)
//   ir_en, ir_sclr        IR load from the top of MDR / clear (always honoured)
//   mem_req, wr_rdn       start an access; direction 1 = write, 0 = read
//   mem_rdata, mem_ack    memory read data and access-complete handshake
//   mem_addr, mem_wdata   MAR and MDR driven to memory
//   mem_cs, mem_we        chip select (READ/WRITE), write enable (WRITE)
//   mdr_q, instruction    MDR and IR contents
//   busy, done, err       access in progress, completion pulse, timeout pulse
module mem_access_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 5,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  busC,
    input  logic [DATA_WIDTH-1:0]  bus_alu,
    input  logic                   mar_en,
    input  logic                   mar_sclr,
    input  logic                   mdr_en,
    input  logic                   mdr_alu_n,
    input  logic                   ir_en,
    input  logic                   ir_sclr,
    input  logic                   mem_req,
    input  logic                   wr_rdn,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_cs,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mdr_q,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   done_nxt;
    logic                   err_nxt;
    logic                   rd_load;
    logic                   idle;

    logic [ADDR_WIDTH-1:0]  mar;
    logic [DATA_WIDTH-1:0]  mdr;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   cs_r;
    logic                   we_r;
    logic                   done_r;
    logic                   err_r;

    assign idle = (state == IDLE);

    // Next-state logic. The direction is fixed by the state entered, so
    // wr_rdn only matters on the IDLE edge that accepts mem_req.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rd_load   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (mem_req) begin
                    state_nxt = wr_rdn ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                // An ack on the final allowed edge still counts as success.
                if (mem_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    rd_load   = (state == READ);
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control state and registered status outputs, decoded from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            cs_r   <= 1'b0;
            we_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cs_r   <= (state_nxt != IDLE);
            we_r   <= (state_nxt == WRITE);
            done_r <= done_nxt;
            err_r  <= err_nxt;
        end
    end

    // MAR is frozen during an access so mem_addr stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mar <= '0;
        end else if (idle) begin
            if (mar_sclr) begin
                mar <= '0;
            end else if (mar_en) begin
                mar <= busC[ADDR_WIDTH-1:0];
            end
        end
    end

    // MDR takes read data on a read ack; bus loads only happen in IDLE so
    // mem_wdata stays stable during a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdr <= '0;
        end else if (rd_load) begin
            mdr <= mem_rdata;
        end else if (idle && mdr_en) begin
            mdr <= mdr_alu_n ? busC : bus_alu;
        end
    end

    // IR samples the pre-edge MDR, so an ir_en on a read-ack edge gets the
    // old MDR value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_sclr) begin
            ir <= '0;
        end else if (ir_en) begin
            ir <= mdr[DATA_WIDTH-1 -: INSTR_WIDTH];
        end
    end

    assign mem_addr    = mar;
    assign mem_wdata   = mdr;
    assign mdr_q       = mdr;
    assign instruction = ir;
    assign mem_cs      = cs_r;
    assign mem_we      = we_r;
    assign busy        = cs_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] busC, bus_alu, mem_rdata;
    logic       mar_en, mar_sclr, mdr_en, mdr_alu_n, ir_en, ir_sclr;
    logic       mem_req, wr_rdn, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mdr_q;
    logic [4:0] instruction;
    logic       mem_cs, mem_we, busy, done, err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] mdr;
    } exp_t;
    exp_t sb[$];
    exp_t sb_e;

    mem_access_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .INSTR_WIDTH(5),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .busC       (busC),
        .bus_alu    (bus_alu),
        .mar_en     (mar_en),
        .mar_sclr   (mar_sclr),
        .mdr_en     (mdr_en),
        .mdr_alu_n  (mdr_alu_n),
        .ir_en      (ir_en),
        .ir_sclr    (ir_sclr),
        .mem_req    (mem_req),
        .wr_rdn     (wr_rdn),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mdr_q      (mdr_q),
        .instruction(instruction),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Advance one edge; inputs set after this are sampled by the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done/err pulse must match the oldest queued access.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_done", done, !sb_e.is_err);
                chk("sb_err", err, sb_e.is_err);
                chk("sb_mdr", mdr_q, sb_e.mdr);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; busC = 8'hFF; bus_alu = 8'hFF; mem_rdata = 8'h00;
        mar_en = 1'b1; mar_sclr = 1'b0; mdr_en = 1'b1; mdr_alu_n = 1'b0;
        ir_en = 1'b0; ir_sclr = 1'b0; mem_req = 1'b1; wr_rdn = 1'b0; mem_ack = 1'b0;

        // Reset held two cycles with loads and request active
        step(); step();
        chk("rst_outputs", {mem_addr, mem_wdata, mdr_q, instruction, mem_cs, mem_we, busy, done, err}, 32'd0);
        rst = 1'b0; mar_en = 1'b0; mdr_en = 1'b0; mem_req = 1'b0;
        step();
        chk("rst_idle_busy", {busy, mem_cs, mem_addr}, 32'd0);

        // Write with ack on the third access cycle
        busC = 8'h3C; mar_en = 1'b1; bus_alu = 8'hA5; mdr_en = 1'b1; mdr_alu_n = 1'b0;
        step();
        mar_en = 1'b0; mdr_en = 1'b0;
        chk("wr_setup_addr", mem_addr, 8'h3C);
        chk("wr_setup_mdr", mdr_q, 8'hA5);
        mem_req = 1'b1; wr_rdn = 1'b1;
        sb.push_back('{is_err: 1'b0, mdr: 8'hA5});
        step();
        mem_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("wr_c%0d_we_cs_busy", c), {mem_we, mem_cs, busy}, 3'b111);
            chk($sformatf("wr_c%0d_addr_data", c), {mem_addr, mem_wdata}, 16'h3CA5);
            chk($sformatf("wr_c%0d_done", c), done, 1'b0);
            if (c == 3) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        chk("wr_done_pulse", {done, err, busy, mem_cs, mem_we}, 5'b10000);
        chk("wr_mdr_kept", mdr_q, 8'hA5);
        step();
        chk("wr_done_one_cycle", done, 1'b0);

        // Read acked on its first cycle, then load IR
        busC = 8'h10; mar_en = 1'b1;
        step();
        mar_en = 1'b0;
        mem_req = 1'b1; wr_rdn = 1'b0;
        sb.push_back('{is_err: 1'b0, mdr: 8'hB7});
        step();
        mem_req = 1'b0;
        chk("rd_cs_we", {mem_cs, mem_we, busy}, 3'b101);
        chk("rd_addr", mem_addr, 8'h10);
        mem_rdata = 8'hB7; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("rd_done_2_edges", {done, busy, mem_cs}, 3'b100);
        chk("rd_mdr", mdr_q, 8'hB7);
        ir_en = 1'b1;
        step();
        ir_en = 1'b0;
        chk("rd_ir", instruction, 5'b10110);
        chk("rd_done_cleared", done, 1'b0);

        // Timeout: read with no ack
        mem_req = 1'b1; wr_rdn = 1'b0; mem_rdata = 8'h55;
        sb.push_back('{is_err: 1'b1, mdr: 8'hB7});
        step();
        mem_req = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && mem_cs; i++) begin
            chk("to_no_pulse_while_cs", {done, err}, 2'b00);
            n++;
            step();
        end
        chk("to_cs_cycles", n, 4);
        chk("to_err_pulse", {err, done, busy}, 3'b100);
        chk("to_mdr_kept", mdr_q, 8'hB7);
        step();
        chk("to_err_one_cycle", err, 1'b0);

        // Ack on the last allowed cycle wins over timeout
        mem_req = 1'b1; wr_rdn = 1'b0; mem_rdata = 8'h5A;
        sb.push_back('{is_err: 1'b0, mdr: 8'h5A});
        step();
        mem_req = 1'b0;
        step(); step(); step();
        chk("to4_still_busy", mem_cs, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to4_done_no_err", {done, err}, 2'b10);
        chk("to4_mdr", mdr_q, 8'h5A);

        // Frozen registers while busy
        mem_req = 1'b1; wr_rdn = 1'b0; mem_rdata = 8'hC3;
        sb.push_back('{is_err: 1'b0, mdr: 8'hC3});
        step();
        mem_req = 1'b1; wr_rdn = 1'b1; busC = 8'hFF; mar_en = 1'b1; mar_sclr = 1'b0;
        mdr_en = 1'b1; mdr_alu_n = 1'b1; ir_sclr = 1'b1; ir_en = 1'b1;
        step();
        mem_req = 1'b0; mar_en = 1'b0; mdr_en = 1'b0; ir_sclr = 1'b0; ir_en = 1'b0;
        chk("frz_addr", mem_addr, 8'h10);
        chk("frz_mdr", mdr_q, 8'h5A);
        chk("frz_ir_sclr", instruction, 5'd0);
        chk("frz_still_read", {mem_cs, mem_we}, 2'b10);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("frz_done", {done, mdr_q}, {1'b1, 8'hC3});
        step();
        chk("frz_req_ignored", {busy, done}, 2'b00);

        // Reset in the second cycle of a write
        mem_req = 1'b1; wr_rdn = 1'b1;
        step();
        mem_req = 1'b0;
        step();
        chk("rstmid_in_write", {mem_cs, mem_we}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_ctrl", {mem_cs, mem_we, busy, done, err}, 5'd0);
        chk("rstmid_regs", {mem_addr, mdr_q}, 16'h0000);
        step(); step();
        chk("rstmid_no_pulse", {done, err, busy}, 3'b000);

        // MDR from busC, and mar_sclr over mar_en
        busC = 8'h6E; mdr_en = 1'b1; mdr_alu_n = 1'b1; bus_alu = 8'h11; mar_en = 1'b1;
        step();
        mdr_en = 1'b0;
        chk("mdr_busc", mdr_q, 8'h6E);
        chk("mar_load", mem_addr, 8'h6E);
        mar_sclr = 1'b1;
        step();
        mar_sclr = 1'b0; mar_en = 1'b0;
        chk("mar_sclr_priority", mem_addr, 8'h00);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
